// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the D5M capture sequencer: state encodings and default timing constants.
package capture_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FROZEN  = 3'd3
  } state_e;

  localparam int DEF_DEB_CYCLES  = 250000;
  localparam int DEF_TIMEOUT_CYC = 25000000;
  localparam int DEF_NUM_FRAMES  = 1;
  localparam int DEF_FCNT_W      = 8;

endpackage

// File: rtl/capture_sequencer_if.sv
// Key/camera inputs and capture/SDRAM control outputs of the capture sequencer.
interface capture_sequencer_if #(
  parameter int FCNT_W = 8
);

  logic              iTRIG_N;
  logic              iABORT;
  logic              iCONT;
  logic              iFVAL;
  logic              oSTART;
  logic              oEND;
  logic              oLOAD;
  logic              oBUSY;
  logic              oFROZEN;
  logic              oERR;
  logic [FCNT_W-1:0] oFRAME_CNT;
  logic [2:0]        oSTATE;

  modport slave (
    input  iTRIG_N, iABORT, iCONT, iFVAL,
    output oSTART, oEND, oLOAD, oBUSY, oFROZEN, oERR, oFRAME_CNT, oSTATE
  );

  modport master (
    output iTRIG_N, iABORT, iCONT, iFVAL,
    input  oSTART, oEND, oLOAD, oBUSY, oFROZEN, oERR, oFRAME_CNT, oSTATE
  );

endinterface

// File: rtl/capture_sequencer_key_debounce.sv
// Active-low key debouncer: 2-FF synchroniser, stable-low counter, one pulse per press.
module capture_sequencer_key_debounce
  import capture_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iKEY_N,
  output logic oPULSE
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Counter saturates at DEB_CYCLES so a held key cannot fire twice.
  always_comb begin
    meta_d  = iKEY_N;
    sync_d  = meta_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync_q) begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else begin
      if (cnt_q == CW'(DEB_CYCLES)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      pulse_d = (cnt_q == CW'(DEB_CYCLES - 1));
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign oPULSE = pulse_q;

endmodule

// File: rtl/capture_sequencer.sv
// D5M capture sequencer: trigger -> wait for vblank -> capture N frames (or live) -> freeze buffer.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FCNT_W      = DEF_FCNT_W
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  capture_sequencer_if.slave  bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic              fval_q, fval_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              frozen_q, frozen_d;
  logic              err_q, err_d;

  logic              trig_s;
  logic              fall_s;
  logic              edge_s;
  logic              busy_s;
  logic              timeout_s;
  logic [FCNT_W-1:0] frame_inc_s;

  capture_sequencer_key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iKEY_N (bus.iTRIG_N),
    .oPULSE (trig_s)
  );

  assign fval_d      = bus.iFVAL;
  assign fall_s      = fval_q & ~bus.iFVAL;
  assign edge_s      = fval_q ^ bus.iFVAL;
  assign busy_s      = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
  assign timeout_s   = busy_s && !edge_s && (wd_q >= WD_W'(TIMEOUT_CYC - 1));
  assign frame_inc_s = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + FCNT_W'(1);

  // Same-cycle priority: abort, then timeout, then frame-complete, then trigger.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    load_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_s && !bus.iABORT) begin
          state_d = ST_ARM;
          load_d  = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (bus.iABORT) begin
          end_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          end_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (!bus.iFVAL) begin
          start_d     = 1'b1;
          frame_cnt_d = '0;
          state_d     = ST_CAPTURE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_CAPTURE: begin
        if (bus.iABORT) begin
          end_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          end_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (fall_s && !bus.iCONT && (frame_inc_s == FCNT_W'(NUM_FRAMES))) begin
          frame_cnt_d = frame_inc_s;
          end_d       = 1'b1;
          state_d     = ST_FROZEN;
        end else if (bus.iCONT && trig_s) begin
          frame_cnt_d = fall_s ? frame_inc_s : frame_cnt_q;
          end_d       = 1'b1;
          state_d     = ST_FROZEN;
        end else if (fall_s) begin
          frame_cnt_d = frame_inc_s;
          state_d     = ST_CAPTURE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_FROZEN: begin
        if (!bus.iABORT && (trig_s || bus.iCONT)) begin
          state_d = ST_ARM;
          load_d  = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = ST_FROZEN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Watchdog restarts on every FVAL edge and on every state change.
  always_comb begin
    wd_d     = '0;
    busy_d   = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
    frozen_d = (state_d == ST_FROZEN);
    if ((state_d != state_q) || !busy_s || edge_s) begin
      wd_d = '0;
    end else if (wd_q == '1) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      fval_q      <= 1'b0;
      frame_cnt_q <= '0;
      wd_q        <= '0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      frozen_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fval_q      <= fval_d;
      frame_cnt_q <= frame_cnt_d;
      wd_q        <= wd_d;
      start_q     <= start_d;
      end_q       <= end_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      frozen_q    <= frozen_d;
      err_q       <= err_d;
    end
  end

  assign bus.oSTART     = start_q;
  assign bus.oEND       = end_q;
  assign bus.oLOAD      = load_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oFROZEN    = frozen_q;
  assign bus.oERR       = err_q;
  assign bus.oFRAME_CNT = frame_cnt_q;
  assign bus.oSTATE     = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scenario bench for capture_sequencer with randomized frame timing and pulse bookkeeping.
module tb_capture_sequencer;

  localparam int DEB = 4;
  localparam int TMO = 200;
  localparam int NFR = 2;
  localparam int FW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  capture_sequencer_if #(.FCNT_W(FW)) bus ();

  capture_sequencer #(
    .DEB_CYCLES  (DEB),
    .NUM_FRAMES  (NFR),
    .TIMEOUT_CYC (TMO),
    .FCNT_W      (FW)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0, n_end = 0, n_load = 0;
  int start_cyc = 0, end_cyc = 0, load_cyc = 0;
  int load_state = 0;
  bit saw_frozen = 1'b0;
  bit end_with_start = 1'b0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.oSTART) begin n_start++; start_cyc = cyc; end
    if (bus.oEND) begin n_end++; end_cyc = cyc; end
    if (bus.oLOAD) begin n_load++; load_cyc = cyc; load_state = int'(bus.oSTATE); end
    if (bus.oFROZEN) saw_frozen = 1'b1;
    if (bus.oSTART && bus.oEND) end_with_start = 1'b1;
  endtask

  task automatic press_key();
    bus.iTRIG_N = 1'b0;
    repeat (10) tick();
    bus.iTRIG_N = 1'b1;
    repeat (6) tick();
  endtask

  task automatic run_frame();
    int hi;
    int lo;
    hi = int'($urandom_range(60, 20));
    lo = int'($urandom_range(15, 5));
    bus.iFVAL = 1'b1;
    repeat (hi) tick();
    bus.iFVAL = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.oSTATE !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.oSTATE); end
    n_cmp++; if ({bus.oBUSY, bus.oFROZEN, bus.oERR} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus.oBUSY, bus.oFROZEN, bus.oERR}); end
    n_cmp++; if (bus.oFRAME_CNT !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.oFRAME_CNT); end
    n_cmp++; if ({bus.oSTART, bus.oEND, bus.oLOAD} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {bus.oSTART, bus.oEND, bus.oLOAD}); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_debounce();
    int l0;
    l0 = n_load;
    bus.iTRIG_N = 1'b0;
    repeat (3) tick();
    bus.iTRIG_N = 1'b1;
    repeat (10) tick();
    n_cmp++; if (n_load != l0) begin n_err++; $display("FAIL short_press_load: got %0d want %0d", n_load, l0); end
    n_cmp++; if (bus.oSTATE !== 3'd0) begin n_err++; $display("FAIL short_press_state: got %0d want 0", bus.oSTATE); end
    bus.iFVAL = 1'b0;
    press_key();
    n_cmp++; if (n_load - l0 != 1) begin n_err++; $display("FAIL long_press_loads: got %0d want 1", n_load - l0); end
    n_cmp++; if (load_state != 1) begin n_err++; $display("FAIL load_in_arm: got state %0d want 1", load_state); end
    n_cmp++; if (start_cyc - load_cyc != 1) begin n_err++; $display("FAIL load_to_start: got %0d want 1", start_cyc - load_cyc); end
    n_cmp++; if (bus.oSTATE !== 3'd2 || bus.oBUSY !== 1'b1) begin n_err++; $display("FAIL armed_capture: got state %0d busy %0d want 2 1", bus.oSTATE, bus.oBUSY); end
  endtask

  task automatic test_single_shot();
    int e0;
    int exp_cnt;
    e0 = n_end;
    for (int k = 1; k <= NFR + 2; k++) begin
      run_frame();
      exp_cnt = (k < NFR) ? k : NFR;
      n_cmp++; if (bus.oFRAME_CNT !== 8'(exp_cnt)) begin n_err++; $display("FAIL single_cnt[%0d]: got %0d want %0d", k, bus.oFRAME_CNT, exp_cnt); end
      n_cmp++; if (bus.oFROZEN !== (k >= NFR)) begin n_err++; $display("FAIL single_frozen[%0d]: got %0d want %0d", k, bus.oFROZEN, k >= NFR); end
      n_cmp++; if (n_end - e0 != ((k >= NFR) ? 1 : 0)) begin n_err++; $display("FAIL single_end[%0d]: got %0d", k, n_end - e0); end
    end
  endtask

  task automatic test_back_to_back();
    int l0, s0, e0;
    for (int r = 0; r < 2; r++) begin
      l0 = n_load; s0 = n_start; e0 = n_end;
      bus.iFVAL = 1'b0;
      press_key();
      n_cmp++; if (n_load - l0 != 1 || n_start - s0 != 1) begin n_err++; $display("FAIL recap_pulses[%0d]: got load %0d start %0d want 1 1", r, n_load - l0, n_start - s0); end
      n_cmp++; if (bus.oFRAME_CNT !== 8'd0) begin n_err++; $display("FAIL recap_cnt_clear[%0d]: got %0d want 0", r, bus.oFRAME_CNT); end
      for (int k = 0; k < NFR; k++) run_frame();
      n_cmp++; if (bus.oFROZEN !== 1'b1 || bus.oFRAME_CNT !== 8'(NFR)) begin n_err++; $display("FAIL recap_done[%0d]: got frozen %0d cnt %0d want 1 %0d", r, bus.oFROZEN, bus.oFRAME_CNT, NFR); end
      n_cmp++; if (n_end - e0 != 1) begin n_err++; $display("FAIL recap_end[%0d]: got %0d want 1", r, n_end - e0); end
    end
  endtask

  task automatic test_continuous();
    int l0, s0, e0, nf;
    l0 = n_load; s0 = n_start;
    bus.iFVAL = 1'b0;
    bus.iCONT = 1'b1;
    repeat (4) tick();
    n_cmp++; if (n_load - l0 != 1 || n_start - s0 != 1 || bus.oSTATE !== 3'd2) begin n_err++; $display("FAIL cont_rearm: got load %0d start %0d state %0d want 1 1 2", n_load - l0, n_start - s0, bus.oSTATE); end
    nf = int'($urandom_range(6, 3));
    e0 = n_end;
    for (int k = 1; k <= nf; k++) begin
      run_frame();
      n_cmp++; if (bus.oFRAME_CNT !== 8'(k)) begin n_err++; $display("FAIL cont_cnt[%0d]: got %0d want %0d", k, bus.oFRAME_CNT, k); end
    end
    n_cmp++; if (n_end != e0) begin n_err++; $display("FAIL cont_no_end: got %0d want 0", n_end - e0); end
    bus.iFVAL = 1'b1;
    repeat (3) tick();
    saw_frozen = 1'b0;
    l0 = n_load;
    press_key();
    n_cmp++; if (n_end - e0 != 1 || saw_frozen !== 1'b1) begin n_err++; $display("FAIL cont_stop: got ends %0d frozen %0d want 1 1", n_end - e0, saw_frozen); end
    n_cmp++; if (n_load - l0 != 1 || bus.oSTATE !== 3'd1) begin n_err++; $display("FAIL cont_relive: got load %0d state %0d want 1 1", n_load - l0, bus.oSTATE); end
    n_cmp++; if (bus.oFRAME_CNT !== 8'(nf)) begin n_err++; $display("FAIL cont_cnt_held: got %0d want %0d", bus.oFRAME_CNT, nf); end
    bus.iCONT = 1'b0;
  endtask

  task automatic test_timeout();
    int e0, l0;
    bit got;
    e0 = n_end;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (n_end != e0) got = 1'b1;
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL timeout_wait: got no oEND want one within 300 cycles"); end
    n_cmp++; if (end_cyc - load_cyc < TMO - 1 || end_cyc - load_cyc > TMO + 1) begin n_err++; $display("FAIL timeout_len: got %0d want %0d", end_cyc - load_cyc, TMO); end
    n_cmp++; if (bus.oERR !== 1'b1 || bus.oSTATE !== 3'd0) begin n_err++; $display("FAIL timeout_err: got err %0d state %0d want 1 0", bus.oERR, bus.oSTATE); end
    bus.iFVAL = 1'b0;
    l0 = n_load;
    press_key();
    n_cmp++; if (bus.oERR !== 1'b0 || n_load - l0 != 1 || bus.oSTATE !== 3'd2) begin n_err++; $display("FAIL err_clear: got err %0d load %0d state %0d want 0 1 2", bus.oERR, n_load - l0, bus.oSTATE); end
  endtask

  task automatic test_abort_final();
    int e0;
    run_frame();
    n_cmp++; if (bus.oFRAME_CNT !== 8'd1) begin n_err++; $display("FAIL abort_pre_cnt: got %0d want 1", bus.oFRAME_CNT); end
    bus.iFVAL = 1'b1;
    repeat (int'($urandom_range(50, 20))) tick();
    e0 = n_end;
    saw_frozen = 1'b0;
    bus.iFVAL = 1'b0;
    bus.iABORT = 1'b1;
    tick();
    bus.iABORT = 1'b0;
    repeat (6) tick();
    n_cmp++; if (bus.oSTATE !== 3'd0 || saw_frozen !== 1'b0) begin n_err++; $display("FAIL abort_state: got state %0d frozen %0d want 0 0", bus.oSTATE, saw_frozen); end
    n_cmp++; if (n_end - e0 != 1) begin n_err++; $display("FAIL abort_end: got %0d want 1", n_end - e0); end
    n_cmp++; if (bus.oFRAME_CNT !== 8'd1) begin n_err++; $display("FAIL abort_cnt_held: got %0d want 1", bus.oFRAME_CNT); end
  endtask

  task automatic test_reset_mid_capture();
    int e0;
    bus.iFVAL = 1'b0;
    press_key();
    run_frame();
    bus.iFVAL = 1'b1;
    repeat (10) tick();
    n_cmp++; if (bus.oSTATE !== 3'd2 || bus.oFRAME_CNT !== 8'd1) begin n_err++; $display("FAIL pre_reset: got state %0d cnt %0d want 2 1", bus.oSTATE, bus.oFRAME_CNT); end
    e0 = n_end;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.oSTATE !== 3'd0 || bus.oFRAME_CNT !== 8'd0 || bus.oBUSY !== 1'b0) begin n_err++; $display("FAIL mid_reset: got state %0d cnt %0d busy %0d want 0 0 0", bus.oSTATE, bus.oFRAME_CNT, bus.oBUSY); end
    rst_n = 1'b1;
    repeat (5) tick();
    n_cmp++; if (n_end != e0 || bus.oSTATE !== 3'd0) begin n_err++; $display("FAIL mid_reset_end: got ends %0d state %0d want 0 0", n_end - e0, bus.oSTATE); end
  endtask

  initial begin
    bus.iTRIG_N = 1'b1;
    bus.iABORT  = 1'b0;
    bus.iCONT   = 1'b0;
    bus.iFVAL   = 1'b0;
    test_reset();
    test_debounce();
    test_single_shot();
    test_back_to_back();
    test_continuous();
    test_timeout();
    test_abort_final();
    test_reset_mid_capture();
    n_cmp++; if (end_with_start !== 1'b0) begin n_err++; $display("FAIL end_with_start: got %0d want 0", end_with_start); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got no completion want finish before 2 ms");
    $fatal(1);
  end

endmodule
